// File: rtl/clk_ratio_monitor_if.sv
// Signal bundle between a divider-under-test environment and clk_ratio_monitor:
// the divided clock, measurement configuration and measurement results.
interface clk_ratio_monitor_if #(
  parameter int CW = 8
);
  logic          en;
  logic          div_in;
  logic [CW-1:0] exp_period;
  logic [CW-1:0] exp_high;
  logic [3:0]    tol;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          err;
  logic          locked;

  modport master (
    output en, div_in, exp_period, exp_high, tol,
    input  period, high_time, meas_valid, err, locked
  );

  modport slave (
    input  en, div_in, exp_period, exp_high, tol,
    output period, high_time, meas_valid, err, locked
  );
endinterface

// File: rtl/clk_ratio_monitor.sv
// Samples an asynchronous divided clock with clk, measures each period and high
// time, checks them against expected values with a tolerance and tracks lock.
module clk_ratio_monitor #(
  parameter int CW       = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  clk_ratio_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

  state_t        state, state_next;
  logic          s1, s2, s3;
  logic          rise, fall;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] h_reg, h_next;
  logic [3:0]    good_cnt, good_next, good_inc;
  logic [CW-1:0] period_q, period_next;
  logic [CW-1:0] high_q, high_next;
  logic          valid_q, valid_next;
  logic          err_q, err_next;
  logic          locked_q, locked_next;

  logic [CW:0]   p_ext, ep_ext, h_ext, eh_ext;
  logic [CW:0]   p_diff, h_diff, tol_ext;
  logic          meas_good;

  // The synchronizer keeps sampling while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign p_ext   = {1'b0, cnt};
  assign ep_ext  = {1'b0, mon.exp_period};
  assign h_ext   = {1'b0, h_reg};
  assign eh_ext  = {1'b0, mon.exp_high};
  assign tol_ext = (CW+1)'(mon.tol);
  assign p_diff  = (p_ext >= ep_ext) ? (p_ext - ep_ext) : (ep_ext - p_ext);
  assign h_diff  = (h_ext >= eh_ext) ? (h_ext - eh_ext) : (eh_ext - h_ext);
  assign meas_good = (p_diff <= tol_ext) && (h_diff <= tol_ext);
  assign good_inc  = (good_cnt >= LOCK_TGT) ? LOCK_TGT : (good_cnt + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      h_reg    <= '0;
      good_cnt <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      h_reg    <= h_next;
      good_cnt <= good_next;
      period_q <= period_next;
      high_q   <= high_next;
      valid_q  <= valid_next;
      err_q    <= err_next;
      locked_q <= locked_next;
    end
  end

  // A rise in MEASURE takes priority over the timeout so a period of exactly CNT_MAX is reported.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    h_next      = h_reg;
    good_next   = good_cnt;
    period_next = period_q;
    high_next   = high_q;
    valid_next  = 1'b0;
    err_next    = err_q;
    locked_next = locked_q;
    if (!mon.en) begin
      state_next  = IDLE;
      cnt_next    = '0;
      h_next      = '0;
      good_next   = '0;
      period_next = '0;
      high_next   = '0;
      err_next    = 1'b0;
      locked_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_next   = CW'(1);
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next = cnt;
            high_next   = h_reg;
            valid_next  = 1'b1;
            cnt_next    = CW'(1);
            if (meas_good) begin
              good_next = good_inc;
              if (good_inc == LOCK_TGT) begin
                locked_next = 1'b1;
              end
            end else begin
              good_next   = '0;
              locked_next = 1'b0;
              err_next    = 1'b1;
            end
          end else if (cnt == CNT_MAX) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
            good_next   = '0;
            state_next  = WAIT_RISE;
          end else begin
            cnt_next = cnt + CW'(1);
            if (fall) begin
              h_next = cnt;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_q;
  assign mon.meas_valid = valid_q;
  assign mon.err        = err_q;
  assign mon.locked     = locked_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench for clk_ratio_monitor: drives div_in synchronously and compares
// every measurement with a reference model built from the waveform's edge times.
module tb_clk_ratio_monitor;

  localparam int CW   = 8;
  localparam int LOCK = 4;
  localparam int LAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  clk_ratio_monitor_if #(.CW(CW)) bus ();

  clk_ratio_monitor #(.CW(CW), .LOCK_CNT(LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int period;
    int high;
    bit err;
    bit locked;
  } exp_t;

  exp_t exp_q[$];
  bit   armed;
  int   last_rise, last_fall, good_n;
  bit   m_err, m_locked;
  int   m_exp_p, m_exp_h, m_tol;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Reference model: works purely on the edge times of the driven waveform.
  task automatic model_rise(input int t);
    int p, h;
    exp_t e;
    if (armed) begin
      p = t - last_rise;
      if (p >= (1 << CW)) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
        good_n   = 0;
      end else begin
        h = last_fall - last_rise;
        if (absdiff(p, m_exp_p) <= m_tol && absdiff(h, m_exp_h) <= m_tol) begin
          if (good_n < LOCK) good_n++;
          if (good_n == LOCK) m_locked = 1'b1;
        end else begin
          good_n   = 0;
          m_locked = 1'b0;
          m_err    = 1'b1;
        end
        e.cyc = t + LAT; e.period = p; e.high = h; e.err = m_err; e.locked = m_locked;
        exp_q.push_back(e);
      end
    end
    armed     = 1'b1;
    last_rise = t;
  endtask

  task automatic model_fall(input int t);
    last_fall = t;
  endtask

  task automatic model_clear();
    armed    = 1'b0;
    good_n   = 0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checkOutput("meas_valid", bus.meas_valid, 1);
      if (bus.meas_valid) begin
        checkOutput("period", bus.period, e.period);
        checkOutput("high_time", bus.high_time, e.high);
        checkOutput("err", bus.err, e.err);
        checkOutput("locked", bus.locked, e.locked);
      end
    end else if (bus.meas_valid) begin
      checkOutput("spurious_valid", bus.meas_valid, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int hi, input int lo);
    bus.div_in = 1'b1;
    model_rise(cyc);
    step(hi);
    bus.div_in = 1'b0;
    model_fall(cyc);
    step(lo);
  endtask

  task automatic check_cleared(input string tag);
    checkOutput({tag, "_period"}, bus.period, 0);
    checkOutput({tag, "_high"}, bus.high_time, 0);
    checkOutput({tag, "_valid"}, bus.meas_valid, 0);
    checkOutput({tag, "_err"}, bus.err, 0);
    checkOutput({tag, "_locked"}, bus.locked, 0);
  endtask

  task automatic start_phase(input int p, input int h, input int t);
    bus.en     = 1'b0;
    bus.div_in = 1'b0;
    step(2);
    model_clear();
    checkOutput("idle_err", bus.err, 0);
    checkOutput("idle_locked", bus.locked, 0);
    bus.exp_period = CW'(p);
    bus.exp_high   = CW'(h);
    bus.tol        = 4'(t);
    m_exp_p = p;
    m_exp_h = h;
    m_tol   = t;
    bus.en  = 1'b1;
    step(4);
  endtask

  task automatic end_phase();
    step(8);
    checkOutput("drained", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, bp, bh, bt, hh, ll;
    bus.en = 1'b0; bus.div_in = 1'b0;
    bus.exp_period = '0; bus.exp_high = '0; bus.tol = '0;
    model_clear();
    step(3);
    check_cleared("reset");
    rst_n = 1'b1;
    step(2);

    $display("[TB] square wave 12/6, tol 0");
    start_phase(12, 6, 0);
    repeat (8) applyStimulus(6, 6);
    end_phase();
    checkOutput("sq_locked", bus.locked, 1);
    checkOutput("sq_err", bus.err, 0);

    $display("[TB] alternating 10/20, tol 7 then 2");
    start_phase(15, 8, 7);
    repeat (4) begin applyStimulus(5, 5); applyStimulus(10, 10); end
    end_phase();
    checkOutput("alt7_locked", bus.locked, 1);
    checkOutput("alt7_err", bus.err, 0);
    start_phase(15, 8, 2);
    repeat (4) begin applyStimulus(5, 5); applyStimulus(10, 10); end
    end_phase();
    checkOutput("alt2_locked", bus.locked, 0);
    checkOutput("alt2_err", bus.err, 1);

    $display("[TB] stretched period after lock");
    start_phase(12, 6, 0);
    repeat (6) applyStimulus(6, 6);
    applyStimulus(6, 8);
    repeat (5) applyStimulus(6, 6);
    end_phase();
    checkOutput("stretch_locked", bus.locked, 1);
    checkOutput("stretch_err", bus.err, 1);

    $display("[TB] stuck high after lock");
    start_phase(12, 6, 0);
    repeat (6) applyStimulus(6, 6);
    bus.div_in = 1'b1;
    model_rise(cyc);
    t0 = cyc;
    step(257);
    checkOutput("pre_timeout_err", bus.err, 0);
    checkOutput("pre_timeout_locked", bus.locked, 1);
    step(1);
    checkOutput("timeout_err", bus.err, 1);
    checkOutput("timeout_locked", bus.locked, 0);
    step(10);
    bus.div_in = 1'b0;
    model_fall(cyc);
    step(5);
    repeat (6) applyStimulus(6, 6);
    end_phase();
    checkOutput("resume_locked", bus.locked, 1);

    $display("[TB] period boundary 255/256");
    start_phase(255, 100, 0);
    repeat (3) applyStimulus(100, 155);
    applyStimulus(100, 156);
    repeat (3) applyStimulus(10, 10);
    end_phase();

    $display("[TB] enable drop and reset pulse mid-period");
    start_phase(12, 6, 0);
    repeat (5) applyStimulus(6, 6);
    bus.div_in = 1'b1;
    model_rise(cyc);
    step(3);
    bus.en = 1'b0;
    step(1);
    check_cleared("en_drop");
    model_clear();
    bus.en = 1'b1;
    step(2);
    bus.div_in = 1'b0;
    model_fall(cyc);
    step(6);
    repeat (6) applyStimulus(6, 6);
    bus.div_in = 1'b1;
    model_rise(cyc);
    step(6);
    bus.div_in = 1'b0;
    model_fall(cyc);
    step(2);
    rst_n = 1'b0;
    #1;
    check_cleared("rst_async");
    step(1);
    rst_n = 1'b1;
    check_cleared("rst_after");
    model_clear();
    step(3);
    repeat (6) applyStimulus(6, 6);
    end_phase();

    $display("[TB] randomized phases");
    repeat (6) begin
      bp = $urandom_range(40, 8);
      bh = $urandom_range(bp - 1, 1);
      bt = $urandom_range(4, 0);
      start_phase(bp, bh, bt);
      repeat (12) begin
        hh = bh + int'($urandom_range(6, 0)) - 3;
        ll = (bp - bh) + int'($urandom_range(6, 0)) - 3;
        if (hh < 1) hh = 1;
        if (ll < 1) ll = 1;
        applyStimulus(hh, ll);
      end
      end_phase();
      checkOutput("rand_err", bus.err, m_err);
      checkOutput("rand_locked", bus.locked, m_locked);
    end

    step(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
